// File: rtl/spio_hss_multiplexer_link_supervisor.sv
// Bring-up and recovery sequencer for one HSS multiplexer link: transceiver reset, lock, mux reset, handshake, link watch.
// Optional: define SPIO_HSS_SUPERVISOR_BACKOFF_EN for exponential retry back-off (x2..x16 of BACKOFF_CYCLES).
module spio_hss_multiplexer_link_supervisor #(
  parameter int GTP_RESET_CYCLES  = 16,
  parameter int MUX_RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT      = 1000000,
  parameter int HANDSHAKE_TIMEOUT = 4000000,
  parameter int LOS_FILTER        = 256,
  parameter int BACKOFF_CYCLES    = 65536,
  parameter int TIMER_BITS        = 24
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic       PLL_LOCKED_IN,
  input  logic       HANDSHAKE_COMPLETE_IN,
  input  logic       VERSION_MISMATCH_IN,
  input  logic [1:0] RXLOSSOFSYNC_IN,
  output logic       GTP_RESET_OUT,
  output logic       MUX_RESET_OUT,
  output logic       LINK_UP_OUT,
  output logic       LINK_DROP_OUT,
  output logic [7:0] RETRY_COUNT_OUT,
  output logic [2:0] STATE_OUT
);

`ifdef SPIO_HSS_SUPERVISOR_BACKOFF_EN
  localparam int TW = TIMER_BITS + 4;
`else
  localparam int TW = TIMER_BITS;
`endif
  localparam int LW = $clog2(LOS_FILTER + 1);

  typedef enum logic [2:0] {
    S_GTP_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_MUX_RST   = 3'd2,
    S_HANDSHAKE = 3'd3,
    S_UP        = 3'd4,
    S_MISMATCH  = 3'd5,
    S_FAIL      = 3'd6,
    S_BACKOFF   = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LW-1:0]   los_q, los_d;
  logic            gtp_q, gtp_d;
  logic            mux_q, mux_d;
  logic            up_q, up_d;
  logic            drop_q, drop_d;
  logic [7:0]      retry_q, retry_d;

  logic            expired;
  logic [LW-1:0]   los_inc;
  logic            los_hit;
  logic [TW-1:0]   backoff_load;
  logic            unused_rxlos0;

  assign expired       = (timer_q == '0);
  assign los_inc       = los_q + 1'b1;
  assign los_hit       = RXLOSSOFSYNC_IN[1] && (los_inc == LW'(LOS_FILTER));
  assign unused_rxlos0 = RXLOSSOFSYNC_IN[0];

`ifdef SPIO_HSS_SUPERVISOR_BACKOFF_EN
  // retry_q already holds the post-increment count while in FAIL, when this is loaded
  logic [2:0] shamt;
  assign shamt        = (retry_q > 8'd4) ? 3'd4 : retry_q[2:0];
  assign backoff_load = (TW'(BACKOFF_CYCLES) << shamt) - 1'b1;
`else
  assign backoff_load = TW'(BACKOFF_CYCLES - 1);
`endif

  // State and registered outputs
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q <= S_GTP_RST;
      timer_q <= TW'(GTP_RESET_CYCLES - 1);
      los_q   <= '0;
      gtp_q   <= 1'b1;
      mux_q   <= 1'b1;
      up_q    <= 1'b0;
      drop_q  <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      los_q   <= los_d;
      gtp_q   <= gtp_d;
      mux_q   <= mux_d;
      up_q    <= up_d;
      drop_q  <= drop_d;
      retry_q <= retry_d;
    end
  end

  // Next state; in HANDSHAKE lock loss beats mismatch beats complete beats timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GTP_RST:   if (expired) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (PLL_LOCKED_IN)  state_d = S_MUX_RST;
        else if (expired)   state_d = S_FAIL;
      end
      S_MUX_RST: begin
        if (!PLL_LOCKED_IN) state_d = S_FAIL;
        else if (expired)   state_d = S_HANDSHAKE;
      end
      S_HANDSHAKE: begin
        if (!PLL_LOCKED_IN)             state_d = S_FAIL;
        else if (VERSION_MISMATCH_IN)   state_d = S_MISMATCH;
        else if (HANDSHAKE_COMPLETE_IN) state_d = S_UP;
        else if (expired)               state_d = S_FAIL;
      end
      S_UP: begin
        if (!PLL_LOCKED_IN || !HANDSHAKE_COMPLETE_IN || los_hit) state_d = S_FAIL;
      end
      S_MISMATCH:  state_d = S_MISMATCH;
      S_FAIL:      state_d = S_BACKOFF;
      S_BACKOFF:   if (expired) state_d = S_GTP_RST;
    endcase
  end

  // Timer, LOS filter and outputs, all derived from the state being entered
  always_comb begin
    timer_d = expired ? '0 : timer_q - 1'b1;
    if (state_d != state_q) begin
      case (state_d)
        S_GTP_RST:   timer_d = TW'(GTP_RESET_CYCLES - 1);
        S_WAIT_LOCK: timer_d = TW'(LOCK_TIMEOUT - 1);
        S_MUX_RST:   timer_d = TW'(MUX_RESET_CYCLES - 1);
        S_HANDSHAKE: timer_d = TW'(HANDSHAKE_TIMEOUT - 1);
        S_BACKOFF:   timer_d = backoff_load;
        default:     timer_d = '0;
      endcase
    end

    los_d = '0;
    if ((state_q == S_UP) && (state_d == S_UP) && RXLOSSOFSYNC_IN[1]) los_d = los_inc;

    gtp_d  = (state_d == S_GTP_RST) || (state_d == S_FAIL) || (state_d == S_BACKOFF);
    mux_d  = gtp_d || (state_d == S_WAIT_LOCK) || (state_d == S_MUX_RST);
    up_d   = (state_d == S_UP);
    drop_d = (state_q == S_UP) && (state_d != S_UP);

    retry_d = retry_q;
    if ((state_d == S_FAIL) && (retry_q != 8'hFF)) retry_d = retry_q + 8'd1;
  end

  assign GTP_RESET_OUT   = gtp_q;
  assign MUX_RESET_OUT   = mux_q;
  assign LINK_UP_OUT     = up_q;
  assign LINK_DROP_OUT   = drop_q;
  assign RETRY_COUNT_OUT = retry_q;
  assign STATE_OUT       = state_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_link_supervisor.sv
// Directed plus randomized bench for the HSS link supervisor against a cycle-age reference model.
module tb_spio_hss_multiplexer_link_supervisor;
  localparam int GTP_N = 4;
  localparam int MUX_N = 4;
  localparam int LOCK_N = 20;
  localparam int HS_N = 30;
  localparam int LOS_N = 3;
  localparam int BO_N = 10;

  logic       clk = 1'b0;
  logic       rst, lock, hc, mm;
  logic [1:0] rxlos;
  logic       gtp, mux, up, drop;
  logic [7:0] retry;
  logic [2:0] st;

  always #5 clk = ~clk;

  spio_hss_multiplexer_link_supervisor #(
    .GTP_RESET_CYCLES(GTP_N), .MUX_RESET_CYCLES(MUX_N), .LOCK_TIMEOUT(LOCK_N),
    .HANDSHAKE_TIMEOUT(HS_N), .LOS_FILTER(LOS_N), .BACKOFF_CYCLES(BO_N), .TIMER_BITS(24)
  ) dut (
    .CLK_IN(clk), .RESET_IN(rst), .PLL_LOCKED_IN(lock), .HANDSHAKE_COMPLETE_IN(hc),
    .VERSION_MISMATCH_IN(mm), .RXLOSSOFSYNC_IN(rxlos), .GTP_RESET_OUT(gtp),
    .MUX_RESET_OUT(mux), .LINK_UP_OUT(up), .LINK_DROP_OUT(drop),
    .RETRY_COUNT_OUT(retry), .STATE_OUT(st)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: state number, cycles spent in it, LOS run length, retry count
  int   m_state = 0;
  int   m_age = 0;
  int   m_los = 0;
  int   m_retry = 0;
  logic m_drop = 1'b0;

  function automatic int bo_len();
`ifdef SPIO_HSS_SUPERVISOR_BACKOFF_EN
    return BO_N << ((m_retry > 4) ? 4 : m_retry);
`else
    return BO_N;
`endif
  endfunction

  function automatic int len_of(input int s);
    case (s)
      0: return GTP_N;
      1: return LOCK_N;
      2: return MUX_N;
      3: return HS_N;
      7: return bo_len();
      default: return 1;
    endcase
  endfunction

  function automatic logic [14:0] model_vec();
    logic g, m, u;
    g = (m_state == 0) || (m_state == 6) || (m_state == 7);
    m = g || (m_state == 1) || (m_state == 2);
    u = (m_state == 4);
    return {3'(m_state), g, m, u, m_drop, 8'(m_retry)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int nxt;
    int run;
    bit ex;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_age = 0; m_los = 0; m_retry = 0; m_drop = 1'b0;
    end else begin
      nxt = m_state;
      run = 0;
      ex  = (m_age == len_of(m_state) - 1);
      case (m_state)
        0: if (ex) nxt = 1;
        1: if (lock) nxt = 2; else if (ex) nxt = 6;
        2: if (!lock) nxt = 6; else if (ex) nxt = 3;
        3: if (!lock) nxt = 6; else if (mm) nxt = 5; else if (hc) nxt = 4; else if (ex) nxt = 6;
        4: begin
          run = rxlos[1] ? m_los + 1 : 0;
          if (!lock || !hc || run >= LOS_N) nxt = 6;
        end
        5: nxt = 5;
        6: nxt = 7;
        default: if (ex) nxt = 0;
      endcase
      m_drop = (m_state == 4) && (nxt != 4);
      if (nxt == 6 && m_retry < 255) m_retry++;
      if (nxt != m_state) begin
        m_age = 0; m_los = 0;
      end else begin
        m_age++; m_los = run;
      end
      m_state = nxt;
    end
    #1;
    check($sformatf("cyc%0d", cyc), {17'd0, st, gtp, mux, up, drop, retry}, {17'd0, model_vec()});
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_state(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (m_state != target && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(st), 32'(target));
  endtask

  initial begin
    int bo;
    int los_pct;
    int hc_pct;
    rst = 1'b1; lock = 1'b0; hc = 1'b0; mm = 1'b0; rxlos = 2'b00;
    run_n(2);
    check("rst_state", 32'(st), 0);
    check("rst_gtp", 32'(gtp), 1);
    check("rst_mux", 32'(mux), 1);
    check("rst_up", 32'(up), 0);
    check("rst_retry", 32'(retry), 0);

    // Bring-up: lock from cycle 0, handshake complete from cycle 12
    rst = 1'b0; lock = 1'b1;
    run_n(3);
    check("gtp_c3", 32'(gtp), 1);
    run_n(1);
    check("gtp_low_c4", 32'(gtp), 0);
    run_n(4);
    check("mux_c8", 32'(mux), 1);
    run_n(1);
    check("mux_low_c9", 32'(mux), 0);
    run_n(3);
    check("up_c12", 32'(up), 0);
    hc = 1'b1;
    run_n(1);
    check("up_c13", 32'(up), 1);
    check("retry_c13", 32'(retry), 0);

    // Loss-of-sync filter
    rxlos = 2'b10; run_n(2);
    rxlos = 2'b00; run_n(1);
    check("los2_up", 32'(up), 1);
    rxlos = 2'b10; run_n(2);
    check("los_pre_up", 32'(up), 1);
    run_n(1);
    check("los3_drop", 32'(drop), 1);
    check("los3_up", 32'(up), 0);
    check("los3_state", 32'(st), 6);
    rxlos = 2'b00; run_n(1);
    check("los_drop_once", 32'(drop), 0);
    check("los_backoff", 32'(st), 7);
    check("los_retry", 32'(retry), 1);
    wait_state(0, 200, "los_restart");

    // Lock never arrives
    lock = 1'b0;
    run_n(GTP_N + LOCK_N);
    check("lockto_state", 32'(st), 6);
    check("lockto_retry", 32'(retry), 2);
    run_n(1);
    bo = bo_len();
    run_n(bo - 1);
    check("bo_last", 32'(st), 7);
    run_n(1);
    check("bo_gtp_again", 32'(gtp), 1);
    check("bo_state", 32'(st), 0);

    // Saturation of the retry counter
    for (int k = 0; k < 300; k++) begin
      wait_state(6, 400, "sat_fail");
      step();
    end
    check("retry_sat", 32'(retry), 255);

    // Version mismatch together with complete
    rst = 1'b1; run_n(1);
    rst = 1'b0; lock = 1'b1; hc = 1'b0;
    wait_state(3, 100, "mm_hs");
    mm = 1'b1; hc = 1'b1;
    run_n(1);
    check("mm_state", 32'(st), 5);
    run_n(1000);
    check("mm_hold", 32'(st), 5);
    check("mm_up", 32'(up), 0);
    check("mm_retry", 32'(retry), 0);
    rst = 1'b1; run_n(1);
    check("mm_exit", 32'(st), 0);
    mm = 1'b0; hc = 1'b0; rst = 1'b0;

    // Reset while the link is up
    lock = 1'b0;
    wait_state(6, 100, "rup_fail");
    lock = 1'b1; hc = 1'b1;
    wait_state(4, 200, "rup_up");
    check("rup_retry", 32'(retry), 1);
    rst = 1'b1; run_n(1);
    check("rup_gtp", 32'(gtp), 1);
    check("rup_mux", 32'(mux), 1);
    check("rup_linkup", 32'(up), 0);
    check("rup_drop", 32'(drop), 0);
    check("rup_retry0", 32'(retry), 0);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      hc_pct  = (i < 2000) ? 85 : 99;
      los_pct = (i < 4000) ? 40 : 10;
      lock  = ($urandom_range(0, 99) < 97);
      hc    = ($urandom_range(0, 99) < hc_pct);
      mm    = ($urandom_range(0, 999) < 3);
      rxlos = {1'($urandom_range(0, 99) < los_pct), 1'($urandom_range(0, 1))};
      rst   = ($urandom_range(0, 999) < 3);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
